store_merge_unit: RTL and testbench

- Write-side counterpart of the load path's sign/zero extension. Takes a 32-bit register value plus a store size (byte, half, word), and places the truncated sub-word into the correct lane of a word-wide data memory.
- The data memory is word-addressed and word-written only, so byte and half stores use a read-modify-write sequence. Word stores write directly.
- Sits between the MEM-stage store request and the data memory port.

---
 rtl/store_merge_unit.sv | 219 +++++++++++++++++++++
 tb/tb_store_merge_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// store_merge_unit: places a byte, half or word store into a word-wide data memory.
// Default build: sub-word stores use read-modify-write and mem_be_o is tied to 4'b1111.
// STORE_BYTE_ENABLE_EN: the memory honours mem_be_o, sub-words are replicated across
// lanes and the READ state is never entered.
module store_merge_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        size_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              mem_wr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_wack_i,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_err;

`ifdef STORE_BYTE_ENABLE_EN
    logic [3:0]        mem_be_q, mem_be_d;
    logic              unused_rd_path;

    // Read port is never used when the memory honours byte enables
    assign unused_rd_path = ^{mem_rdata_i, mem_rvalid_i};
`else
    logic [1:0]        lane_q, lane_d;
    logic              is_byte_q, is_byte_d;
    logic [15:0]       sub_q, sub_d;
    logic [31:0]       merged;

    // Replace the selected lane of the read word with the latched sub-word
    always_comb begin
        merged = mem_rdata_i;
        if (is_byte_q) begin
            case (lane_q)
                2'd0:    merged[7:0]   = sub_q[7:0];
                2'd1:    merged[15:8]  = sub_q[7:0];
                2'd2:    merged[23:16] = sub_q[7:0];
                default: merged[31:24] = sub_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = sub_q;
        end else begin
            merged[15:0] = sub_q;
        end
    end
`endif

    // Misaligned half/word or reserved size, judged on the incoming request
    always_comb begin
        req_err = 1'b0;
        case (size_i)
            SZ_HALF: req_err = addr_i[0];
            SZ_WORD: req_err = (addr_i[1:0] != 2'b00);
            SZ_RSVD: req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef STORE_BYTE_ENABLE_EN
        mem_be_d    = mem_be_q;
`else
        lane_d      = lane_q;
        is_byte_d   = is_byte_q;
        sub_d       = sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
`ifndef STORE_BYTE_ENABLE_EN
                    lane_d    = addr_i[1:0];
                    is_byte_d = (size_i == SZ_BYTE);
                    sub_d     = wdata_i[15:0];
`endif
                    if (req_err) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (size_i == SZ_WORD) begin
                        state_d     = S_WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = wdata_i;
`ifdef STORE_BYTE_ENABLE_EN
                        mem_be_d    = 4'b1111;
`endif
                    end else begin
`ifdef STORE_BYTE_ENABLE_EN
                        state_d  = S_WRITE;
                        mem_wr_d = 1'b1;
                        if (size_i == SZ_BYTE) begin
                            mem_wdata_d = {4{wdata_i[7:0]}};
                            mem_be_d    = 4'(4'b0001 << addr_i[1:0]);
                        end else begin
                            mem_wdata_d = {2{wdata_i[15:0]}};
                            mem_be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                        end
`else
                        state_d  = S_READ;
                        mem_rd_d = 1'b1;
`endif
                    end
                end
            end
`ifndef STORE_BYTE_ENABLE_EN
            S_READ: begin
                if (mem_rvalid_i) begin
                    state_d     = S_WRITE;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = merged;
                end
            end
`endif
            S_WRITE: begin
                if (mem_wack_i) begin
                    state_d  = S_RESP;
                    mem_wr_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef STORE_BYTE_ENABLE_EN
            mem_be_q    <= 4'b0000;
`else
            lane_q      <= 2'b00;
            is_byte_q   <= 1'b0;
            sub_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef STORE_BYTE_ENABLE_EN
            mem_be_q    <= mem_be_d;
`else
            lane_q      <= lane_d;
            is_byte_q   <= is_byte_d;
            sub_q       <= sub_d;
`endif
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
`ifdef STORE_BYTE_ENABLE_EN
    assign mem_be_o    = mem_be_q;
`else
    assign mem_be_o    = 4'b1111;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: randomized stores against a word-array memory model;
// expected memory contents, latency and handshake counts come from lane arithmetic.
`timescale 1ns/1ps
module tb_store_merge_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  size_i;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;
    logic        mem_wr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_wack_i;
    logic        done_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [1024];
    int          last_lat;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i),
        .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_wack_i(mem_wack_i), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle invariants
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("rd_wr_exclusive", 32'(mem_rd_o & mem_wr_o), 32'd0);
            check("addr_aligned", 32'(mem_addr_o[1:0]), 32'd0);
`ifndef STORE_BYTE_ENABLE_EN
            check("be_tied", 32'(mem_be_o), 32'hF);
`endif
        end
    end

    // One store transaction with the bench acting as memory
    task automatic do_store(input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input int rdly, input int wdly);
        bit          exp_err, exp_rmw;
        int          exp_rd, exp_wr, exp_lat, idx;
        int          rd_cyc, wr_cyc, done_cnt, done_at;
        logic [31:0] shift, mask, old_word, exp_word, exp_wdata;
        logic [31:0] raddr, waddr, wdata_seen, bm;
        logic [3:0]  exp_be, be_seen;
        logic        err_seen;

        idx      = int'(a[11:2]);
        old_word = mem[idx];
        exp_err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        case (sz)
            2'b00:   begin shift = 32'(a[1:0]) * 8;  mask = 32'hFF << shift;   end
            2'b01:   begin shift = 32'(a[1]) * 16;   mask = 32'hFFFF << shift; end
            default: begin shift = 0;                mask = 32'hFFFF_FFFF;     end
        endcase
        exp_word = exp_err ? old_word : ((old_word & ~mask) | ((wd << shift) & mask));
`ifdef STORE_BYTE_ENABLE_EN
        exp_rmw = 1'b0;
        for (int k = 0; k < 4; k++) exp_be[k] = mask[8*k];
        exp_wdata = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
`else
        exp_rmw   = !exp_err && (sz != 2'b10);
        exp_be    = 4'hF;
        exp_wdata = exp_word;
`endif
        exp_rd  = exp_rmw ? rdly + 1 : 0;
        exp_wr  = exp_err ? 0 : wdly + 1;
        exp_lat = exp_err ? 1 : exp_rd + exp_wr + 1;

        rd_cyc = 0; wr_cyc = 0; done_cnt = 0; done_at = 0; err_seen = 1'b0;
        raddr = '0; waddr = '0; wdata_seen = '0; be_seen = '0;

        @(negedge clk_i);
        check("ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; addr_i = a; wdata_i = wd; size_i = sz;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; size_i = 2'($urandom);

        for (int c = 1; c <= exp_lat + 1; c++) begin
            @(negedge clk_i);
            if (mem_rd_o) begin
                rd_cyc++;
                raddr = mem_addr_o;
                mem_rvalid_i = (rd_cyc > rdly);
                mem_rdata_i  = mem_rvalid_i ? mem[int'(mem_addr_o[11:2])] : $urandom;
            end else begin
                mem_rvalid_i = 1'($urandom);
                mem_rdata_i  = $urandom;
            end
            if (mem_wr_o) begin
                wr_cyc++;
                waddr = mem_addr_o; wdata_seen = mem_wdata_o; be_seen = mem_be_o;
                mem_wack_i = (wr_cyc > wdly);
                if (mem_wack_i) begin
                    for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{mem_be_o[k]}};
                    mem[int'(mem_addr_o[11:2])] = (mem[int'(mem_addr_o[11:2])] & ~bm) | (mem_wdata_o & bm);
                end
            end else begin
                mem_wack_i = 1'($urandom);
            end
            if (done_o) begin
                done_cnt++; done_at = c; err_seen = err_o;
            end
            check("ready_busy", 32'(req_ready_o), 32'(c > exp_lat));
        end
        mem_rvalid_i = 1'b0; mem_wack_i = 1'b0;

        check("done_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_at), 32'(exp_lat));
        check("err", 32'(err_seen), 32'(exp_err));
        check("rd_cycles", 32'(rd_cyc), 32'(exp_rd));
        check("wr_cycles", 32'(wr_cyc), 32'(exp_wr));
        check("mem_word", mem[idx], exp_word);
        if (exp_rd > 0) check("rd_addr", raddr, {a[31:2], 2'b00});
        if (exp_wr > 0) begin
            check("wr_addr", waddr, {a[31:2], 2'b00});
            check("wr_data", wdata_seen, exp_wdata);
            check("wr_be", 32'(be_seen), 32'(exp_be));
        end
        last_lat = done_at; last_wdata = wdata_seen; last_be = be_seen;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = '0;
        mem_rdata_i = '0; mem_rvalid_i = 1'b0; mem_wack_i = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // Reset state
        @(negedge clk_i);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_rd_wr", 32'({mem_rd_o, mem_wr_o}), 32'd0);
        check("rst_done_err", 32'({done_o, err_o}), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Byte store, zero-wait
        mem[32'h100 >> 2] = 32'h1122_3344;
        do_store(32'h0000_0102, 32'hDEAD_BEAA, 2'b00, 0, 0);
        check("byte_literal", mem[32'h100 >> 2], 32'h11AA_3344);
`ifndef STORE_BYTE_ENABLE_EN
        check("byte_lat_literal", 32'(last_lat), 32'd3);
`endif

        // Half store, read data delayed 3 cycles
        mem[32'h204 >> 2] = 32'hFFFF_FFFF;
        do_store(32'h0000_0204, 32'h0000_CAFE, 2'b01, 3, 0);
        check("half_literal", mem[32'h204 >> 2], 32'hFFFF_CAFE);

        // Word store, write ack delayed 2 cycles
        do_store(32'h0000_0300, 32'h1234_5678, 2'b10, 0, 2);
        check("word_literal", mem[32'h300 >> 2], 32'h1234_5678);
        check("word_lat_literal", 32'(last_lat), 32'd4);

        // Error cases
        do_store(32'h0000_0101, 32'h0000_BEEF, 2'b01, 0, 0);
        check("err_lat_literal", 32'(last_lat), 32'd1);
        do_store(32'h0000_0200, 32'h0000_BEEF, 2'b11, 0, 0);

`ifdef STORE_BYTE_ENABLE_EN
        // Byte-enable build: direct write with replicated data
        do_store(32'h0000_0403, 32'h0000_0077, 2'b00, 0, 0);
        check("be_literal", 32'(last_be), 32'h8);
        check("be_wdata_literal", last_wdata, 32'h7777_7777);
        check("be_lat_literal", 32'(last_lat), 32'd2);
`endif

        // Reset while a sub-word store waits on memory
        @(negedge clk_i);
        req_valid_i = 1'b1; addr_i = 32'h0000_0501; wdata_i = 32'h55; size_i = 2'b00;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        check("pre_rst_busy", 32'(mem_rd_o | mem_wr_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_rd", 32'(mem_rd_o), 32'd0);
        check("rst_mid_wr", 32'(mem_wr_o), 32'd0);
        check("rst_mid_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("post_rst_quiet", 32'({mem_rd_o, mem_wr_o, done_o}), 32'd0);
            check("post_rst_ready", 32'(req_ready_o), 32'd1);
        end
        do_store(32'h0000_0600, 32'hA5A5_0F0F, 2'b10, 0, 1);

        // Randomized stores
        for (int n = 0; n < 80; n++) begin
            do_store($urandom, $urandom, 2'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
